// File: rtl/taxi_mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO initiator: opcodes, frame
// constants, controller state encoding and the frame-word builder.
package taxi_mdio_pkg;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_ST       = 2'b01;

  localparam int unsigned PRE_LEN   = 32;
  localparam int unsigned FRAME_LEN = 32;
  // ST + OP + PHYAD + REGAD, i.e. the bits ahead of TA
  localparam int unsigned HDR_LEN   = 14;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    FRAME,
    DONE,
    RESP
  } mdio_state_t;

  // Frame word after the preamble, MSB transmitted first. In read-format
  // frames the TA/DATA positions are released, so their contents are unused.
  function automatic logic [FRAME_LEN-1:0] mdio_frame(
    input logic [1:0]  op,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] data
  );
    logic [1:0] ta;
    ta = op[1] ? 2'b11 : 2'b10;
    return {MDIO_ST, op, phy_addr, reg_addr, ta, data};
  endfunction

endpackage

// File: rtl/taxi_mdio_mdc_gen.sv
// MDC generator: divides clk by 2*PRESCALE while enabled, holds MDC low
// otherwise. rise_c/fall_c mark the clk edge on which MDC goes 0->1 / 1->0.
// Ports:
//   clk, rst  core clock, async active-high reset
//   en        run the generator (frame in progress)
//   mdc       registered MDC output
//   rise_c    MDC rises on the coming clock edge
//   fall_c    MDC falls on the coming clock edge
module taxi_mdio_mdc_gen #(
  parameter int unsigned PRESCALE = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;
  logic             tc_c;

  assign tc_c   = en && (cnt == CNT_MAX);
  assign rise_c = tc_c && !mdc;
  assign fall_c = tc_c && mdc;

  // Prescale counter and MDC toggle; cleared whenever the generator is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tc_c) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/taxi_mdio_master.sv
// IEEE 802.3 Clause 22 MDIO management initiator.
// One read/write command at a time via cmd_*; read data returned on rsp_*.
// mdio_o/mdio_t/mdio_i map onto an external IOBUF (mdio_t=1 releases).
// Optional feature macro: TAXI_MDIO_PREAMBLE_SUPPRESS_EN adds cmd_no_pre,
// which skips the 32-bit preamble for that frame.
// Ports:
//   clk, rst                     core clock, async active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/phy_addr/reg_addr     opcode (01 write, 10 read), PHYAD, REGAD
//   cmd_wr_data                  write data
//   rsp_valid/rsp_ready/rsp_data read response
//   busy                         frame in progress
//   mdc_o, mdio_i/mdio_o/mdio_t  management bus
module taxi_mdio_master
  import taxi_mdio_pkg::*;
#(
  parameter int unsigned MDC_PRESCALE = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wr_data,
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_pre,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        mdc_o,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  localparam int unsigned CNT_W      = 5;
  // bit_cnt value while the first TA bit is on the wire
  localparam int unsigned TA_BIT_CNT = FRAME_LEN - 1 - HDR_LEN;

  mdio_state_t      state;
  logic [31:0]      shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             rd_op;
  logic [15:0]      rd_shreg;
  logic             mdc_en_c;
  logic             rise_c;
  logic             fall_c;
  logic             no_pre_c;

`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
  assign no_pre_c = cmd_no_pre;
`else
  assign no_pre_c = 1'b0;
`endif

  assign mdc_en_c = (state == PRE) || (state == FRAME);

  taxi_mdio_mdc_gen #(
    .PRESCALE(MDC_PRESCALE)
  ) u_mdc_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (mdc_en_c),
    .mdc   (mdc_o),
    .rise_c(rise_c),
    .fall_c(fall_c)
  );

  // Frame controller: bits change on MDC fall, are sampled on MDC rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rd_op     <= 1'b0;
      rd_shreg  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shreg     <= mdio_frame(cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wr_data);
            rd_op     <= cmd_op[1];
            bit_cnt   <= CNT_W'(PRE_LEN - 1);
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            mdio_t    <= 1'b0;
            if (no_pre_c) begin
              state  <= FRAME;
              mdio_o <= MDIO_ST[1];
            end else begin
              state  <= PRE;
              mdio_o <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        PRE: begin
          if (fall_c) begin
            if (bit_cnt == '0) begin
              state   <= FRAME;
              bit_cnt <= CNT_W'(FRAME_LEN - 1);
              mdio_o  <= shreg[31];
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end

        FRAME: begin
          // shifts through TA too; the last 16 samples are the DATA field
          if (rise_c) begin
            rd_shreg <= {rd_shreg[14:0], mdio_i};
          end
          if (fall_c) begin
            if (bit_cnt == '0) begin
              state  <= DONE;
              mdio_o <= 1'b1;
              mdio_t <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
              shreg   <= shreg << 1;
              mdio_o  <= shreg[30];
              // release from TA onward in read-format frames
              mdio_t  <= rd_op && (bit_cnt <= CNT_W'(TA_BIT_CNT + 1));
            end
          end
        end

        DONE: begin
          busy <= 1'b0;
          if (rd_op) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_shreg;
            state     <= RESP;
          end else begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_mdio_master.sv
// Self-checking bench for taxi_mdio_master: two instances (MDC_PRESCALE 4
// and 1), a PHY responder model, and a frame-level reference built from the
// Clause 22 field layout.
module tb_taxi_mdio_master;
  import taxi_mdio_pkg::*;

  localparam int unsigned P_SLOW = 4;
  localparam int unsigned P_FAST = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wr_data;
  logic        rsp_ready;
  logic        mdio_i;
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
  logic        cmd_no_pre;
`endif

  wire [1:0]       cmd_ready;
  wire [1:0]       rsp_valid;
  wire [1:0][15:0] rsp_data;
  wire [1:0]       busy;
  wire [1:0]       mdc;
  wire [1:0]       mdio_o;
  wire [1:0]       mdio_t;

  int cur;
  int n_tests;
  int n_fail;

  always #4 clk = ~clk;

  taxi_mdio_master #(.MDC_PRESCALE(P_SLOW)) u_slow (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wr_data(cmd_wr_data),
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre(cmd_no_pre),
`endif
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .mdc_o(mdc[0]), .mdio_i(mdio_i),
    .mdio_o(mdio_o[0]), .mdio_t(mdio_t[0])
  );

  taxi_mdio_master #(.MDC_PRESCALE(P_FAST)) u_fast (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wr_data(cmd_wr_data),
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre(cmd_no_pre),
`endif
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .mdc_o(mdc[1]), .mdio_i(mdio_i),
    .mdio_o(mdio_o[1]), .mdio_t(mdio_t[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (inst %0d)", tag, got, exp, cur);
    end
  endtask

  // Whole frame as seen on the wire, right-aligned, MSB first
  function automatic logic [63:0] ref_bits(input logic [1:0] op, input logic [4:0] pa,
                                           input logic [4:0] ra, input logic [15:0] wd);
    logic [1:0] ta;
    ta = op[1] ? 2'b11 : 2'b10;
    return {32'hFFFF_FFFF, 2'b01, op, pa, ra, ta, wd};
  endfunction

  // PHY responder: value on MDIO for wire bit k (0 = first bit sent)
  function automatic logic phy_bit(input int k, input int nbits, input logic [15:0] rd);
    int idx;
    idx = k - (nbits - 32);
    if (idx == 15) return 1'b0;
    if (idx >= 16 && idx <= 31) return rd[31 - idx];
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] rd, input bit no_pre,
                           input int abort_at, input bit hold);
    int p, nbits, rises, toggles, busy_cyc, guard, limit;
    logic [63:0] eo, et, oo, ot, mask;
    logic prev;
    p      = (cur == 1) ? int'(P_FAST) : int'(P_SLOW);
    nbits  = no_pre ? 32 : 64;
    mask   = no_pre ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    eo     = ref_bits(op, pa, ra, wd) & mask;
    et     = {46'b0, {18{op[1]}}} & mask;
    oo = '0; ot = '0; rises = 0; toggles = 0; guard = 0;

    while (cmd_ready[cur] !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", 64'(cmd_ready[cur]), 64'd1);

    cmd_op = op; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wr_data = wd;
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
    cmd_no_pre = no_pre;
`endif
    mdio_i = phy_bit(0, nbits, rd);
    cmd_valid[cur] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[cur] = 1'b0;
    cmd_op = 2'($urandom); cmd_wr_data = 16'($urandom);
    check("first_bit", {61'd0, mdc[cur], mdio_t[cur], mdio_o[cur]},
          {61'd0, 1'b0, 1'b0, eo[nbits-1]});

    busy_cyc = 1; prev = 1'b0; guard = 0;
    limit = 2 * p * nbits + 20;
    while (busy[cur] === 1'b1 && guard < limit) begin
      @(negedge clk);
      guard++;
      if (busy[cur] === 1'b1) busy_cyc++;
      if (mdc[cur] !== prev) toggles++;
      if (mdc[cur] === 1'b1 && prev === 1'b0) begin
        oo = {oo[62:0], mdio_o[cur]};
        ot = {ot[62:0], mdio_t[cur]};
        rises++;
        mdio_i = phy_bit(rises, nbits, rd);
      end
      prev = mdc[cur];
      if (abort_at >= 0 && rises == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_bus", {60'd0, mdc[cur], mdio_t[cur], mdio_o[cur], busy[cur]},
              {60'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("abort_rsp", {46'd0, rsp_valid[cur], cmd_ready[cur], rsp_data[cur]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mdio_i = 1'b1;
        return;
      end
    end
    check("busy_timeout", 64'(busy[cur]), 64'd0);
    check("rises", 64'(rises), 64'(nbits));
    check("mdc_toggles", 64'(toggles), 64'(2 * nbits));
    check("busy_cycles", 64'(busy_cyc), 64'(2 * p * nbits + 1));
    check("bits_o", oo & ~et, eo & ~et);
    check("bits_t", ot, et);
    mdio_i = 1'b1;

    if (op[1]) begin
      check("rsp_valid", 64'(rsp_valid[cur]), 64'd1);
      check("rsp_data", 64'(rsp_data[cur]), 64'(rd));
      check("rdy_in_resp", 64'(cmd_ready[cur]), 64'd0);
      if (!hold) begin
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_pop", {62'd0, rsp_valid[cur], cmd_ready[cur]}, 64'd1);
      end
    end else begin
      check("wr_no_rsp", {62'd0, rsp_valid[cur], cmd_ready[cur]}, 64'd1);
    end
  endtask

  task automatic run_random(input int n);
    logic [1:0] op;
    bit np;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      np = 1'b0;
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
      np = 1'($urandom_range(0, 1));
`endif
      run_frame(op, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), np, -1, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] held;
    bit bad_rdy, bad_data;
    n_tests = 0; n_fail = 0; cur = 0;
    rst = 1'b1; cmd_valid = '0; rsp_ready = 1'b0; mdio_i = 1'b1;
    cmd_op = '0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wr_data = '0;
`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
    cmd_no_pre = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_outs", {52'd0, mdc, mdio_o, mdio_t, cmd_ready, rsp_valid, busy},
          {52'd0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00});
    check("rst_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd3);

    // Directed write and read at prescale 4
    run_frame(MDIO_OP_WRITE, 5'd5, 5'h1F, 16'hA5C3, 16'h0000, 1'b0, -1, 1'b0);
    run_frame(MDIO_OP_READ, 5'd1, 5'd2, 16'h0000, 16'h1234, 1'b0, -1, 1'b0);

    // Response backpressure with a pending command
    run_frame(MDIO_OP_READ, 5'd7, 5'd9, 16'h0000, 16'h5AF0, 1'b0, -1, 1'b1);
    held = rsp_data[cur];
    bad_rdy = 1'b0; bad_data = 1'b0;
    cmd_valid[cur] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready[cur] !== 1'b0 || rsp_valid[cur] !== 1'b1) bad_rdy = 1'b1;
      if (rsp_data[cur] !== held) bad_data = 1'b1;
    end
    check("bp_ready_held", 64'(bad_rdy), 64'd0);
    check("bp_data_stable", 64'(bad_data), 64'd0);
    check("bp_data", 64'(held), 64'h5AF0);
    cmd_valid[cur] = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {62'd0, rsp_valid[cur], cmd_ready[cur]}, 64'd1);

    // Reset in the middle of a read, then a clean frame
    run_frame(MDIO_OP_READ, 5'd3, 5'd4, 16'h0000, 16'hBEEF, 1'b0, 40, 1'b0);
    run_frame(MDIO_OP_READ, 5'd3, 5'd4, 16'h0000, 16'hC0DE, 1'b0, -1, 1'b0);

    run_random(4);

`ifdef TAXI_MDIO_PREAMBLE_SUPPRESS_EN
    run_frame(MDIO_OP_WRITE, 5'd5, 5'h1F, 16'hA5C3, 16'h0000, 1'b1, -1, 1'b0);
    run_frame(MDIO_OP_READ, 5'd1, 5'd2, 16'h0000, 16'h8001, 1'b1, -1, 1'b0);
`endif

    // Minimum prescale instance
    cur = 1;
    run_frame(MDIO_OP_WRITE, 5'd5, 5'h1F, 16'hA5C3, 16'h0000, 1'b0, -1, 1'b0);
    run_frame(MDIO_OP_READ, 5'd31, 5'd0, 16'h0000, 16'hFFFE, 1'b0, -1, 1'b0);
    run_random(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/taxi_mdio_master.md
Name: taxi_mdio_master

Overview:
- IEEE 802.3 Clause 22 MDIO management initiator. Drives MDC/MDIO toward the 1000BASE-T PHY, which is the MDIO responder.
- Sits inside the core on the 125 MHz domain.
- Accepts one read or write command at a time through a valid/ready interface.
- Returns read data through a valid/ready response channel.
- The top level maps mdio_o/mdio_t/mdio_i onto an IOBUF for phy_mdio.

Parameters:
- MDC_PRESCALE, 25, core clocks per MDC half-period. The MDC period is 2*MDC_PRESCALE clocks (2.5 MHz at 125 MHz). Legal range is 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  MDIO opcode (01 = write, 10 = read)
- cmd_phy_addr  in  5  PHYAD
- cmd_reg_addr  in  5  REGAD
- cmd_wr_data  in  16  write data
- cmd_no_pre  in  1  skip the preamble (present only with the macro)
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  response accepted
- rsp_data  out  16  read data
- busy  out  1  frame in progress
- mdc_o  out  1  MDC
- mdio_i  in  1  MDIO input; already synchronised externally
- mdio_o  out  1  MDIO output value
- mdio_t  out  1  MDIO tristate; 1 = released

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - mdc_o=0, mdio_o=1, mdio_t=1
  - cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0
  - state=IDLE
- cmd_ready rises on the first clock edge after rst deasserts.
- Bit timing (MDC generator):
  - The prescale counter counts 0..MDC_PRESCALE-1.
  - At terminal count, mdc_o toggles.
  - A fall strobe accompanies each 1->0 transition; a rise strobe accompanies each 0->1 transition.
  - The generator runs only while busy; mdc_o is held 0 in IDLE.
- mdio_o/mdio_t update on the fall strobe. The first bit is driven in the cycle the command is accepted, with MDC low.
- mdio_i is sampled on the rise strobe.
- Frame, MSB first:
  - PRE: 32 ones
  - ST: 01
  - OP: cmd_op
  - PHYAD: 5 bits
  - REGAD: 5 bits
  - TA: write-format = 10; read-format = released for 2 bits
  - DATA: 16 bits
- Frame length is 64 bits, or 32 bits when the preamble is skipped.
- Read-format means cmd_op[1]=1. Write-format means cmd_op[1]=0. ST is always 01.
- For read-format frames, mdio_t=1 from TA through DATA. The 16 sampled DATA bits form rsp_data.
- The second TA bit is sampled but ignored.
- States and transitions:
  - IDLE -> PRE, or -> FRAME when the preamble is skipped, on handshake. The command fields are latched into a 32-bit shift register and a bit counter is loaded.
  - PRE -> FRAME after 32 bits.
  - FRAME -> DONE after the last DATA bit's rising-edge half completes, i.e. at the next fall strobe.
  - DONE: mdc_o=0, mdio_t=1, mdio_o=1.
    - For read-format: rsp_valid=1, go to RESP.
    - Otherwise go to IDLE.
  - RESP: hold rsp_valid and rsp_data until rsp_ready, then go to IDLE.
- cmd_ready=1 only in IDLE, and not while rsp_valid=1. A new command therefore cannot overwrite unread data.
- busy=1 in PRE, FRAME, DONE.
- cmd_* inputs are ignored outside the handshake cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately, the bus is released, and any partial read data is discarded.
- MDC_PRESCALE=1: MDC period is 2 clocks; the rise/fall strobes alternate every cycle.

Optional Feature:
- Macro: TAXI_MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: the cmd_no_pre port exists. When it is 1 at accept, PRE is skipped and the 32-bit frame begins directly with ST.
- Undefined: the port is absent and every frame carries the full 32-bit preamble.

Decomposition:
- Package taxi_mdio_pkg:
  - opcode constants MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10
  - ST constant 2'b01
  - state enum (IDLE, PRE, FRAME, DONE, RESP)
  - PRE_LEN=32, FRAME_LEN=32
- Sub-module taxi_mdio_mdc_gen: prescale counter, mdc_o, rise/fall strobes, enable input.

Test Plan:
- Write:
  - Stimulus: MDC_PRESCALE=4, op=01, phy=5, reg=0x1F, data=0xA5C3.
  - Response: 64 MDC cycles, each 8 clocks. The bitstream captured on MDC rise is 32x1, 01, 01, 00101, 11111, 10, 1010010111000011. mdio_t stays 0 throughout. No rsp_valid.
- Read:
  - Stimulus: op=10, phy=1, reg=2; the PHY model drives 0 on TA2, then 0x1234.
  - Response: mdio_t=1 from TA1 onward. rsp_valid=1 with rsp_data=0x1234 after the last bit.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 100 cycles while cmd_valid=1.
  - Response: cmd_ready stays 0 and rsp_data is stable. One cycle after rsp_ready=1, rsp_valid=0 and cmd_ready=1.
- Reset mid-frame:
  - Stimulus: assert rst at bit 40 of a read.
  - Response: mdc_o=0, mdio_t=1, busy=0 in the same cycle without a clock edge. The next command after release produces a clean, full frame.
- Minimum prescale:
  - Stimulus: MDC_PRESCALE=1 write.
  - Response: MDC toggles every clock and the frame completes in 128 clocks.
- With TAXI_MDIO_PREAMBLE_SUPPRESS_EN:
  - Stimulus: a write with cmd_no_pre=1.
  - Response: the first driven bits are 0,1 (ST), with a total of 32 MDC cycles.
